// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the fetch PC and issues one instruction-memory read at a time.
// It captures each returned word with its PC and offers the pair to the decode
// stage and instruction queue. Redirects retarget the PC and discard any stale
// in-flight response.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_addr/rmask     read request (rmask 4'hf while a request is outstanding)
//   imem_rdata/resp     returned word, one-cycle response strobe
//   inst_valid/rdata/pc instruction held for the decoder
//   inst_push           instruction accepted by the queue this cycle
//   iq_full             queue cannot accept
//   redirect_valid/pc   one-cycle redirect request and target
//   push_count          number of accepted instructions (wraps)
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      imem_addr,
    output logic [3:0]       imem_rmask,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_resp,
    output logic             inst_valid,
    output logic [31:0]      inst_rdata,
    output logic [31:0]      inst_pc,
    output logic             inst_push,
    input  logic             iq_full,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] push_count
);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_PUSH  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [31:0]       pc, pc_n;
    logic              run;
    logic              valid_n;
    logic [31:0]       rdata_n, ipc_n;
    logic [CNT_W-1:0]  count_n;
    logic [31:0]       target;

    // Redirect targets are always word aligned.
    assign target     = {redirect_pc[31:2], 2'b00};
    assign imem_addr  = {pc[31:2], 2'b00};
    // run keeps the request low while in reset; it rises on the first edge after release.
    assign imem_rmask = (state == S_WAIT && run) ? 4'hf : 4'h0;
    assign inst_push  = inst_valid & ~iq_full & ~redirect_valid;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_WAIT;
            pc         <= RESET_PC;
            run        <= 1'b0;
            inst_valid <= 1'b0;
            inst_rdata <= '0;
            inst_pc    <= '0;
            push_count <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            run        <= 1'b1;
            inst_valid <= valid_n;
            inst_rdata <= rdata_n;
            inst_pc    <= ipc_n;
            push_count <= count_n;
        end
    end

    // Next-state logic; redirect wins over capture and push everywhere.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        valid_n = inst_valid;
        rdata_n = inst_rdata;
        ipc_n   = inst_pc;
        count_n = push_count;
        unique case (state)
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_n    = target;
                    // A response arriving with the redirect is dropped; reissue next cycle.
                    state_n = imem_resp ? S_WAIT : S_FLUSH;
                end else if (imem_resp) begin
                    rdata_n = imem_rdata;
                    ipc_n   = pc;
                    valid_n = 1'b1;
                    pc_n    = pc + 32'(4);
                    state_n = S_PUSH;
                end
            end
            S_PUSH: begin
                if (redirect_valid) begin
                    valid_n = 1'b0;
                    pc_n    = target;
                    state_n = S_WAIT;
                end else if (!iq_full) begin
                    valid_n = 1'b0;
                    count_n = push_count + CNT_W'(1);
                    state_n = S_WAIT;
                end
            end
            S_FLUSH: begin
                if (redirect_valid) pc_n = target;
                if (imem_resp)      state_n = S_WAIT;
            end
            default: state_n = S_WAIT;
        endcase
    end

    a_no_resp_in_push: assert property (@(posedge clk) disable iff (!rst_n)
        (state == S_PUSH) |-> !imem_resp);

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (inst_valid && !inst_push && !redirect_valid) |=> ($stable(inst_rdata) && $stable(inst_pc)));

    a_rmask_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (state != S_WAIT) |-> (imem_rmask == 4'h0));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: inputs driven at the falling
// edge, outputs sampled 1 time unit later; the memory is modelled by hand.
module tb_fetch_ctrl;

    localparam logic [31:0] RPC = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        inst_valid;
    logic [31:0] inst_rdata;
    logic [31:0] inst_pc;
    logic        inst_push;
    logic        iq_full;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] push_count;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.RESET_PC(RPC), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .inst_valid(inst_valid), .inst_rdata(inst_rdata), .inst_pc(inst_pc),
        .inst_push(inst_push), .iq_full(iq_full),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .push_count(push_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a request, then check its address.
    task automatic wait_req(input logic [31:0] addr);
        int n = 0;
        #1;
        while (imem_rmask != 4'hf && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("req_seen", 32'(imem_rmask), 32'hf);
        check("req_addr", imem_addr, addr);
    endtask

    // Respond lat cycles after the request; returns at the capture+1 cycle.
    task automatic respond(input int lat, input logic [31:0] data);
        repeat (lat) @(negedge clk);
        imem_resp  = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_resp  = 1'b0;
        imem_rdata = 32'h0;
        #1;
    endtask

    logic [31:0] hold_rdata, hold_pc;

    initial begin
        rst_n = 1'b0; imem_rdata = '0; imem_resp = 1'b0; iq_full = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;

        // Reset values
        @(negedge clk); #1;
        check("rst_addr", imem_addr, RPC);
        check("rst_rmask", 32'(imem_rmask), 32'h0);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_rdata", inst_rdata, 32'h0);
        check("rst_ipc", inst_pc, 32'h0);
        check("rst_count", push_count, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Three sequential fetches, latency 1
        for (int k = 0; k < 3; k++) begin
            wait_req(RPC + 32'(4 * k));
            respond(1, 32'hA000_0000 + 32'(k));
            check("seq_valid", 32'(inst_valid), 32'h1);
            check("seq_push", 32'(inst_push), 32'h1);
            check("seq_pc", inst_pc, RPC + 32'(4 * k));
            check("seq_rdata", inst_rdata, 32'hA000_0000 + 32'(k));
        end
        @(negedge clk); #1;
        check("seq_count", push_count, 32'd3);

        // Backpressure: iq_full for 5 cycles after capture
        wait_req(RPC + 32'hc);
        iq_full = 1'b1;
        respond(1, 32'hBEEF_0001);
        hold_rdata = inst_rdata;
        hold_pc    = inst_pc;
        check("bp_rdata0", hold_rdata, 32'hBEEF_0001);
        check("bp_pc0", hold_pc, RPC + 32'hc);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            check("bp_valid", 32'(inst_valid), 32'h1);
            check("bp_push", 32'(inst_push), 32'h0);
            check("bp_rmask", 32'(imem_rmask), 32'h0);
            check("bp_rdata", inst_rdata, hold_rdata);
            check("bp_pc", inst_pc, hold_pc);
        end
        @(negedge clk); iq_full = 1'b0; #1;
        check("bp_release_push", 32'(inst_push), 32'h1);
        @(negedge clk); #1;
        check("bp_next_rmask", 32'(imem_rmask), 32'hf);
        check("bp_next_addr", imem_addr, RPC + 32'h10);
        check("bp_count", push_count, 32'd4);

        // Redirect in WAIT; stale response 3 cycles later
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
        @(negedge clk); redirect_valid = 1'b0; #1;
        check("fl_rmask", 32'(imem_rmask), 32'h0);
        check("fl_addr", imem_addr, 32'h0000_1000);
        @(negedge clk);
        @(negedge clk); imem_resp = 1'b1; imem_rdata = 32'hDEAD_DEAD;
        @(negedge clk); imem_resp = 1'b0; #1;
        check("fl_valid", 32'(inst_valid), 32'h0);
        check("fl_rmask2", 32'(imem_rmask), 32'hf);
        check("fl_addr2", imem_addr, 32'h0000_1000);
        respond(1, 32'h1111_2222);
        check("fl_push", 32'(inst_push), 32'h1);
        check("fl_pc", inst_pc, 32'h0000_1000);
        check("fl_rdata", inst_rdata, 32'h1111_2222);

        // Redirect coincident with response; unaligned target
        wait_req(32'h0000_1004);
        @(negedge clk);
        imem_resp = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2003;
        @(negedge clk);
        imem_resp = 1'b0; redirect_valid = 1'b0; #1;
        check("co_valid", 32'(inst_valid), 32'h0);
        check("co_rmask", 32'(imem_rmask), 32'hf);
        check("co_addr", imem_addr, 32'h0000_2000);
        respond(1, 32'h3333_4444);
        check("co_pc", inst_pc, 32'h0000_2000);
        check("co_count_pre", push_count, 32'd5);

        // Redirect while holding an instruction in PUSH
        wait_req(32'h0000_2004);
        respond(1, 32'h5555_6666);
        redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc; #1;
        check("rp_push", 32'(inst_push), 32'h0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        check("rp_valid", 32'(inst_valid), 32'h0);
        check("rp_count", push_count, 32'd6);
        check("rp_rmask", 32'(imem_rmask), 32'hf);
        check("rp_addr", imem_addr, 32'hffff_fffc);

        // PC wrap at top of address space
        respond(1, 32'h7777_8888);
        check("wr_push", 32'(inst_push), 32'h1);
        check("wr_pc", inst_pc, 32'hffff_fffc);
        @(negedge clk); #1;
        check("wr_addr", imem_addr, 32'h0000_0000);
        check("wr_rmask", 32'(imem_rmask), 32'hf);
        check("wr_count", push_count, 32'd7);

        // Asynchronous reset mid-WAIT, away from any clock edge
        #2 rst_n = 1'b0; #1;
        check("ar_addr", imem_addr, RPC);
        check("ar_rmask", 32'(imem_rmask), 32'h0);
        check("ar_valid", 32'(inst_valid), 32'h0);
        check("ar_rdata", inst_rdata, 32'h0);
        check("ar_ipc", inst_pc, 32'h0);
        check("ar_count", push_count, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        wait_req(RPC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
